// File: rtl/midi_pkg.sv
// Shared constants, message type and helpers for the MIDI receive front end.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package midi_pkg;

  localparam int DEF_CLK_HZ   = 100000000;
  localparam int DEF_BAUD     = 31250;
  localparam int CLKS_PER_BIT = DEF_CLK_HZ / DEF_BAUD;

  // Channel-voice status classes (upper nibble of the status byte)
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  // System common/exclusive and realtime byte ranges
  localparam logic [7:0] SYS_MIN = 8'hF0;
  localparam logic [7:0] RT_MIN  = 8'hF8;

  // Bit offsets of the fields inside the 32-bit message word
  localparam int MSG_STATUS_LSB = 16;
  localparam int MSG_DATA1_LSB  = 8;
  localparam int MSG_DATA2_LSB  = 0;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
  } msg_t;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  // Number of data bytes that complete a message of the given status
  function automatic logic [1:0] data_count(input logic [7:0] status);
    logic [1:0] n;
    case (status[7:4])
      NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: n = 2'd2;
      PROG, CHAN_AT:                         n = 2'd1;
      default:                               n = 2'd0;
    endcase
    return n;
  endfunction

  // Place a message into the CPU-visible word; the top byte stays zero
  function automatic logic [31:0] msg_word(input msg_t m);
    logic [31:0] w;
    w = '0;
    w[MSG_STATUS_LSB +: 8] = m.status;
    w[MSG_DATA1_LSB  +: 8] = m.data1;
    w[MSG_DATA2_LSB  +: 8] = m.data2;
    return w;
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver: 2-FF input synchronizer plus start/data/stop FSM.
// Latency: byte strobe one cycle after the stop-bit sample (mid stop bit).
// Backpressure: none; the consumer must take each byte on its strobe.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int BIT_CLKS = CLKS_PER_BIT
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       midi_in,
  output logic [7:0] byte_data,
  output logic       byte_stb,
  output logic       frame_err
);

  localparam int              CW       = $clog2(BIT_CLKS + 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0]   HALF_CNT = CW'(BIT_CLKS / 2 - 1);

  logic [1:0]    sync;
  logic          rx;
  logic          rx_prev;
  uart_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          stb_nxt;
  logic          err_nxt;

  assign rx        = sync[1];
  assign byte_data = shreg;

  // Bring the idle-high line into the clock domain and keep one cycle of history for edge detection
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], midi_in};
      rx_prev <= rx;
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state     <= WAIT_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shreg     <= shreg_nxt;
      byte_stb  <= stb_nxt;
      frame_err <= err_nxt;
    end
  end

  // Next-state and bit-timing logic
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    stb_nxt     = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      // A full bit time of continuous high keeps us from locking onto the middle of a frame
      WAIT_IDLE: begin
        if (!rx) begin
          cnt_nxt = '0;
        end else if (cnt == LAST_CNT) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      IDLE: begin
        cnt_nxt = '0;
        if (rx_prev && !rx) state_nxt = START;
      end
      // Re-check the start bit at its centre; a short low pulse is just noise
      START: begin
        if (cnt == HALF_CNT) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx, shreg[7:1]};
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_idx_nxt = bit_idx + 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_nxt = '0;
          if (rx) begin
            stb_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/midi_rx_frontend.sv
// MIDI input stage: UART, running-status message parser and a CPU-readable message FIFO.
// Latency: message pushed two cycles after the last stop-bit sample; pop 3-4 cycles after a toggle.
// Backpressure: none upstream; a message arriving with the FIFO full is dropped and flagged.
module midi_rx_frontend
  import midi_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int BAUD       = DEF_BAUD,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          CLK100MHZ,
  input  logic                          reset,
  input  logic                          midi_in,
  input  logic                          rd_toggle,
  output logic [31:0]                   msg_data,
  output logic                          msg_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          framing_err
);

  localparam int               BIT_CLKS = CLK_HZ / BAUD;
  localparam int               PW       = $clog2(FIFO_DEPTH);
  localparam int               CNTW     = PW + 1;
  localparam logic [CNTW-1:0]  FULL_CNT = CNTW'(FIFO_DEPTH);

  logic [7:0]    byte_data;
  logic          byte_stb;
  logic          frame_err;

  logic [2:0]    tg;
  logic          pop;

  logic [7:0]    run_status;
  logic          rs_valid;
  logic          data_idx;
  logic [7:0]    data1_q;
  logic          push_vld;
  msg_t          push_msg;

  msg_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          do_pop;
  logic          do_push;

  midi_uart_rx #(
    .BIT_CLKS (BIT_CLKS)
  ) u_uart (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .midi_in   (midi_in),
    .byte_data (byte_data),
    .byte_stb  (byte_stb),
    .frame_err (frame_err)
  );

  // Note-on with zero velocity is delivered as a note-off so software sees one form
  function automatic msg_t make_msg(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2);
    msg_t m;
    m.status = st;
    m.data1  = d1;
    m.data2  = d2;
    if (st[7:4] == NOTE_ON && d2 == 8'h00) m.status = {NOTE_OFF, st[3:0]};
    return m;
  endfunction

  // Toggle-to-pulse: each level change of the CPU request becomes a single pop cycle
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) tg <= 3'b000;
    else       tg <= {tg[1:0], rd_toggle};
  end

  assign pop = tg[1] ^ tg[2];

  // Running-status parser; realtime bytes pass through without disturbing a message in progress
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      run_status <= '0;
      rs_valid   <= 1'b0;
      data_idx   <= 1'b0;
      data1_q    <= '0;
      push_vld   <= 1'b0;
      push_msg   <= '0;
    end else begin
      push_vld <= 1'b0;
      if (byte_stb && byte_data < RT_MIN) begin
        if (byte_data >= SYS_MIN) begin
          rs_valid <= 1'b0;
          data_idx <= 1'b0;
        end else if (byte_data[7]) begin
          run_status <= byte_data;
          rs_valid   <= 1'b1;
          data_idx   <= 1'b0;
        end else if (rs_valid) begin
          if (!data_idx && data_count(run_status) == 2'd1) begin
            push_vld <= 1'b1;
            push_msg <= make_msg(run_status, byte_data, 8'h00);
          end else if (!data_idx) begin
            data1_q  <= byte_data;
            data_idx <= 1'b1;
          end else begin
            push_vld <= 1'b1;
            push_msg <= make_msg(run_status, data1_q, byte_data);
            data_idx <= 1'b0;
          end
        end
      end
    end
  end

  assign empty   = (fifo_count == '0);
  assign full    = (fifo_count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot the push needs
  assign do_push = push_vld && (!full || do_pop);

  // Message storage; contents are only visible through the occupancy-gated head
  always_ff @(posedge CLK100MHZ) begin
    if (do_push) mem[wr_ptr] <= push_msg;
  end

  // FIFO pointers, occupancy and sticky error flags
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      overflow    <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push_vld && !do_push) overflow <= 1'b1;
      if (frame_err)            framing_err <= 1'b1;
    end
  end

  assign msg_valid = !empty;
  assign msg_data  = empty ? 32'h0 : msg_word(mem[rd_ptr]);

endmodule
